// File: rtl/mcu.sv
// Memory-to-memory micro-controller core: 2^mem_sz x op_sz register-file memory
// feeding a single-cycle ALU; one instruction retires per clock.
module mcu #(
    parameter int op_sz  = 32,
    parameter int mem_sz = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [mem_sz-1:0] op0,
    input  logic [op_sz-1:0]  op1,
    input  logic [mem_sz-1:0] op2,
    input  logic [3:0]        op,
    output logic [op_sz-1:0]  out,
    output logic              op_err
);
    localparam int depth = 1 << mem_sz;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_DIV   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_READ  = 4'd7,
        OP_WRITE = 4'd8
    } opcode_t;

    logic [op_sz-1:0]  mem [depth];
    logic [op_sz-1:0]  src_a, src_b, res;
    logic [mem_sz-1:0] wr_addr;
    logic              wr_en, out_en, err;

    // Operands come from pre-edge memory, so a same-cycle write never forwards.
    assign src_a = mem[op0];
    assign src_b = mem[op1[mem_sz-1:0]];

    always_comb begin
        res     = '0;
        err     = 1'b0;
        wr_en   = 1'b1;
        out_en  = 1'b1;
        wr_addr = op2;
        case (opcode_t'(op))
            OP_ADD: res = src_a + src_b;
            OP_SUB: res = src_a - src_b;
            OP_MUL: res = src_a * src_b;
            OP_DIV: begin
                if (src_b == '0) begin
                    res = '1;
                    err = 1'b1;
                end else begin
                    res = src_a / src_b;
                end
            end
            OP_AND: res = src_a & src_b;
            OP_OR:  res = src_a | src_b;
            OP_XOR: res = src_a ^ src_b;
            OP_READ: begin
                res   = src_a;
                wr_en = 1'b0;
            end
            OP_WRITE: begin
                res     = op1;
                wr_addr = op0;
            end
            default: begin
                err    = 1'b1;
                wr_en  = 1'b0;
                out_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= '0;
            op_err <= 1'b0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else begin
            op_err <= err;
            if (out_en) out <= res;
            if (wr_en) mem[wr_addr] <= res;
        end
    end
endmodule

// File: tb/tb_mcu.sv
// Self-checking bench for mcu: directed test-plan sequence plus randomized ops
// compared against an arithmetic reference model of memory, out and op_err.
module tb_mcu;
    localparam int OPW = 32;
    localparam int AW  = 10;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW-1:0]   op0, op2;
    logic [OPW-1:0]  op1;
    logic [3:0]      op;
    logic [OPW-1:0]  out;
    logic            op_err;

    int n_chk = 0;
    int n_fail = 0;

    longint unsigned ref_mem [1 << AW];
    longint unsigned ref_out;
    bit              ref_err;

    mcu #(.op_sz(OPW), .mem_sz(AW)) dut (
        .clk(clk), .reset(reset), .op0(op0), .op1(op1), .op2(op2),
        .op(op), .out(out), .op_err(op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        op = 4'd0; op0 = '0; op1 = '0; op2 = '0;
        @(posedge clk);
        #1;
        foreach (ref_mem[i]) ref_mem[i] = 0;
        ref_out = 0;
        ref_err = 0;
        chk("reset_out", out, '0);
        chk("reset_err", {31'b0, op_err}, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one instruction, advance the model by the instruction's rules, compare.
    task automatic step(input logic [3:0] o, input logic [AW-1:0] a0,
                        input logic [OPW-1:0] a1, input logic [AW-1:0] a2,
                        input string tag);
        longint unsigned a, b, r;
        logic [AW-1:0] baddr;
        @(negedge clk);
        op = o; op0 = a0; op1 = a1; op2 = a2;
        @(posedge clk);
        baddr = a1[AW-1:0];
        a = ref_mem[a0];
        b = ref_mem[baddr];
        r = 0;
        case (o)
            4'd0: r = (a + b) % MOD;
            4'd1: r = (a + MOD - b) % MOD;
            4'd2: r = (a * b) % MOD;
            4'd3: r = (b == 0) ? MOD - 1 : a / b;
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = a;
            4'd8: r = longint'(a1);
            default: r = ref_out;
        endcase
        if (o <= 4'd6 || o == 4'd3) ref_mem[a2] = r;
        if (o == 4'd8) ref_mem[a0] = r;
        ref_out = r;
        ref_err = (o > 4'd8) || (o == 4'd3 && b == 0);
        #1;
        chk({tag, "_out"}, out, ref_out[OPW-1:0]);
        chk({tag, "_err"}, {31'b0, op_err}, {31'b0, ref_err});
    endtask

    initial begin
        logic [OPW-1:0] keep;
        reset = 1'b0; op = '0; op0 = '0; op1 = '0; op2 = '0;
        do_reset();

        step(4'd7, 10'd5, 32'd0, 10'd0, "read_after_reset");
        chk("read5_const", out, 32'd0);

        step(4'd8, 10'd3, 32'd19, 10'd0, "write3");
        step(4'd8, 10'd4, 32'd25, 10'd0, "write4");
        step(4'd7, 10'd3, 32'd0, 10'd0, "read3");
        chk("read3_const", out, 32'd19);
        step(4'd7, 10'd4, 32'd0, 10'd0, "read4");
        chk("read4_const", out, 32'd25);

        for (int k = 0; k <= 6; k++) begin
            logic [OPW-1:0] want [7];
            want = '{32'd44, 32'd6, 32'd475, 32'd1, 32'd17, 32'd27, 32'd10};
            step(k[3:0], 10'd4, 32'd3, 10'(6 + k), $sformatf("alu%0d", k));
            chk($sformatf("alu%0d_const", k), out, want[k]);
        end
        step(4'd7, 10'd6, 32'd0, 10'd0, "read6");
        chk("read6_const", out, 32'd44);
        step(4'd7, 10'd12, 32'd0, 10'd0, "read12");
        chk("read12_const", out, 32'd10);

        step(4'd1, 10'd3, 32'd4, 10'd13, "sub_wrap");
        chk("sub_wrap_const", out, 32'hFFFF_FFFA);
        step(4'd8, 10'd20, 32'h1_0000, 10'd0, "w20");
        step(4'd8, 10'd21, 32'h1_0000, 10'd0, "w21");
        step(4'd2, 10'd20, 32'd21, 10'd22, "mul_trunc");
        chk("mul_trunc_const", out, 32'd0);

        // Upper op1 bits must be ignored when op1 is used as an address.
        step(4'd0, 10'd3, 32'hABCD_0004, 10'd23, "op1_hi_ignored");
        chk("op1_hi_const", out, 32'd44);

        step(4'd3, 10'd4, 32'd30, 10'd24, "div0");
        chk("div0_const", out, 32'hFFFF_FFFF);
        chk("div0_err_const", {31'b0, op_err}, 32'd1);
        step(4'd0, 10'd3, 32'd4, 10'd25, "add_clr");
        chk("add_clr_err_const", {31'b0, op_err}, 32'd0);

        keep = out;
        step(4'd12, 10'd3, 32'd4, 10'd3, "invalid");
        chk("invalid_hold", out, keep);
        step(4'd7, 10'd3, 32'd0, 10'd0, "read_after_invalid");
        chk("mem_unchanged", out, 32'd19);

        step(4'd0, 10'd5, 32'd5, 10'd5, "dst_eq_src_seed");
        step(4'd8, 10'd5, 32'd7, 10'd0, "w5");
        step(4'd0, 10'd5, 32'd5, 10'd5, "dst_eq_src");
        step(4'd7, 10'd5, 32'd0, 10'd0, "dst_eq_src_read");
        chk("dst_eq_src_const", out, 32'd14);

        for (int n = 0; n < 400; n++) begin
            logic [3:0]     o;
            logic [OPW-1:0] d;
            o = (($urandom_range(0, 3)) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (o == 4'd8)
                step(o, 10'($urandom_range(0, 15)), d, 10'd0, "rnd_w");
            else
                step(o, 10'($urandom_range(0, 15)),
                     {$urandom_range(0, 1) == 0 ? 22'd0 : 22'($urandom), 10'($urandom_range(0, 15))},
                     10'($urandom_range(0, 15)), "rnd");
        end

        do_reset();
        for (int i = 0; i < 16; i++) step(4'd7, 10'(i), 32'd0, 10'd0, "read_after_reset2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mcu.md
Name: mcu

Overview:
- Minimal memory-to-memory micro-controller core: a register-file memory of 2^mem_sz words of op_sz bits, plus a single-cycle ALU.
- One opcode is accepted per clock. Each instruction reads up to two memory operands, computes a result, writes it back to memory and presents it on out.
- Used as a standalone execution unit driven directly by an instruction source (opcode plus operand fields) every cycle.

Parameters:
- op_sz, 32, data word width (memory word, ALU width, op1 width, out width).
- mem_sz, 10, address width; memory depth = 2^mem_sz words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op0  input  mem_sz  first source address (ALU ops); address for read/write.
- op1  input  op_sz  second source address for ALU ops (low mem_sz bits used, upper bits ignored); write data for op 8.
- op2  input  mem_sz  destination address for ALU ops.
- op  input  4  opcode.
- out  output  op_sz  registered result.
- op_err  output  1  registered error flag for the current instruction.

Behaviour:
- Reset (reset=1 at a rising edge):
  - out<=0, op_err<=0.
  - All memory words <=0.
  - No instruction executes that cycle; reset takes priority over any op.
- Latency: the instruction presented before rising edge N is executed at edge N; out, op_err and memory reflect it immediately after edge N (1-cycle latency).
- Operand fetch: sources are read combinationally from memory contents before the edge (A = mem[op0], B = mem[op1[mem_sz-1:0]]). A write in the same cycle is not visible to its own operands.
- Opcodes (R = result; for ALU ops mem[op2]<=R, out<=R, op_err<=0):
  - 0 ADD: R = A+B, modulo 2^op_sz (wrap, no carry out).
  - 1 SUB: R = A-B, modulo 2^op_sz (unsigned wrap).
  - 2 MUL: R = low op_sz bits of A*B (unsigned).
  - 3 DIV: R = A/B, unsigned integer quotient, truncating.
    - B=0: R = all ones, written to mem[op2] and out, op_err<=1.
  - 4 AND: R = A&B.
  - 5 OR: R = A|B.
  - 6 XOR: R = A^B.
  - 7 READ: out<=mem[op0]; op_err<=0; memory unchanged.
  - 8 WRITE: mem[op0]<=op1; out<=op1; op_err<=0.
  - 9–15 invalid: op_err<=1; out holds previous value; memory unchanged.
- op_err covers only the current instruction; it clears on the next valid instruction.
- Destination equal to a source: the new value is written; out shows the result.
- Back-to-back instructions need no stall or handshake; a new op is accepted every cycle.

Test Plan:
- Reset held 1 cycle, then READ op0=5 -> out=0, op_err=0.
- WRITE (3,19), WRITE (4,25), then READ 3 -> out=19; READ 4 -> out=25; op_err=0 throughout.
- With mem[4]=25 and mem[3]=19, ops 0..6 with op0=4, op1=3, op2=6..12 -> out = 44, 6, 475, 1, 17, 27, 10 respectively; then READ 6 -> 44 and READ 12 -> 10.
- SUB op0=3, op1=4 -> out=0xFFFFFFFA. MUL of 0x10000 by 0x10000 -> out=0 (truncation).
- DIV with mem[op1]=0 -> out=0xFFFFFFFF and op_err=1; the following valid ADD clears op_err to 0.
- op=12 -> op_err=1, out unchanged from the previous value, memory unchanged (verify by READ); a subsequent READ clears op_err.
